// File: rtl/stream_arb_mux_if.sv
// Stream bundle between N_CH input channels and the single arbitrated output slot.
// master drives the channel inputs and the downstream ready; slave is the arbiter.
interface stream_arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 4
);
    localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1;

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [SEL_W-1:0]      out_ch;
    logic [15:0]           xfer_cnt;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch, xfer_cnt
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch, xfer_cnt
    );
endinterface

// File: rtl/stream_arb_mux.sv
// N-channel stream arbiter feeding one registered output slot; round-robin,
// fixed-priority or externally selected grant, plus a wrapping transfer counter.
module stream_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 4,
    parameter int MODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    stream_arb_mux_if.slave   bus
);
    localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1;

    logic [WIDTH-1:0] ch_data [N_CH];
    logic [N_CH-1:0]  grant;

    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_ch_reg;
    logic             out_valid_reg;
    logic [SEL_W-1:0] ptr_reg;
    logic [15:0]      cnt_reg;

    logic             ld;
    logic             rr_any, fp_any, sl_any, gnt_any;
    logic [SEL_W-1:0] rr_idx, fp_idx, sl_idx, gnt_idx;
    logic [SEL_W-1:0] ptr_next;
    int               j;

    assign ld = !out_valid_reg || bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
            assign grant[gi]   = gnt_any && (gnt_idx == SEL_W'(gi));
        end
    endgenerate

    // All three arbiters are evaluated; the mode parameter picks one.
    // Loops run downward so the last hit is the nearest candidate.
    always_comb begin
        rr_any = 1'b0;
        rr_idx = '0;
        fp_any = 1'b0;
        fp_idx = '0;
        j      = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            j = int'(ptr_reg) + k;
            if (j >= N_CH) j = j - N_CH;
            if (bus.in_valid[j]) begin
                rr_any = 1'b1;
                rr_idx = SEL_W'(j);
            end
            if (bus.in_valid[k]) begin
                fp_any = 1'b1;
                fp_idx = SEL_W'(k);
            end
        end
        sl_idx = bus.sel;
        sl_any = (int'(bus.sel) < N_CH) && bus.in_valid[bus.sel];

        if (MODE == 1) begin
            gnt_any = fp_any;
            gnt_idx = fp_idx;
        end else if (MODE == 2) begin
            gnt_any = sl_any;
            gnt_idx = sl_idx;
        end else begin
            gnt_any = rr_any;
            gnt_idx = rr_idx;
        end
    end

    assign ptr_next = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            ptr_reg       <= '0;
            cnt_reg       <= '0;
        end else begin
            if (out_valid_reg && bus.out_ready) cnt_reg <= cnt_reg + 16'd1;
            if (ld) begin
                if (gnt_any) begin
                    out_data_reg  <= ch_data[gnt_idx];
                    out_ch_reg    <= gnt_idx;
                    out_valid_reg <= 1'b1;
                    if (MODE != 1 && MODE != 2) ptr_reg <= ptr_next;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    // Ready is forced low during reset even though the slot is empty then.
    assign bus.in_ready  = (ld && !rst) ? grant : '0;
    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.xfer_cnt  = cnt_reg;
endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: one instance per arbitration mode on a
// shared clock and reset, each checked against hand-computed values.
module tb_stream_arb_mux;
    localparam int WIDTH = 32;
    localparam int N_CH  = 4;

    logic clk;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    stream_arb_mux_if #(.WIDTH(WIDTH), .N_CH(N_CH)) b_rr ();
    stream_arb_mux_if #(.WIDTH(WIDTH), .N_CH(N_CH)) b_fp ();
    stream_arb_mux_if #(.WIDTH(WIDTH), .N_CH(N_CH)) b_sel ();

    stream_arb_mux #(.WIDTH(WIDTH), .N_CH(N_CH), .MODE(0)) u_rr  (.clk(clk), .rst(rst), .bus(b_rr));
    stream_arb_mux #(.WIDTH(WIDTH), .N_CH(N_CH), .MODE(1)) u_fp  (.clk(clk), .rst(rst), .bus(b_fp));
    stream_arb_mux #(.WIDTH(WIDTH), .N_CH(N_CH), .MODE(2)) u_sel (.clk(clk), .rst(rst), .bus(b_sel));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("  ok  %s = %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        b_rr.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        b_rr.in_valid  = 4'hF;
        b_rr.sel       = '0;
        b_rr.out_ready = 1'b1;
        b_fp.in_data   = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        b_fp.in_valid  = 4'h0;
        b_fp.sel       = '0;
        b_fp.out_ready = 1'b1;
        b_sel.in_data  = {32'hC3, 32'hDEADBEEF, 32'hC1, 32'hC0};
        b_sel.in_valid = 4'h0;
        b_sel.sel      = '0;
        b_sel.out_ready = 1'b1;

        #12;
        check("rst out_valid", 32'(b_rr.out_valid), 32'd0);
        check("rst out_data",  b_rr.out_data,        32'd0);
        check("rst out_ch",    32'(b_rr.out_ch),    32'd0);
        check("rst xfer_cnt",  32'(b_rr.xfer_cnt),  32'd0);
        check("rst in_ready",  32'(b_rr.in_ready),  32'd0);
        step();
        check("rst held across edge", 32'(b_rr.out_valid), 32'd0);
        rst = 1'b0;
        #1;

        // Round-robin rotation with all channels valid and sink always ready
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr in_ready c%0d", i), 32'(b_rr.in_ready), 32'(4'b0001 << (i % 4)));
            step();
            check($sformatf("rr out_ch c%0d", i),   32'(b_rr.out_ch),   32'(i % 4));
            check($sformatf("rr out_data c%0d", i), b_rr.out_data,       32'hA0 + 32'(i % 4));
            check($sformatf("rr out_valid c%0d", i), 32'(b_rr.out_valid), 32'd1);
            check($sformatf("rr xfer_cnt c%0d", i), 32'(b_rr.xfer_cnt), 32'(i));
        end

        // Stall: slot full, sink not ready
        b_rr.out_ready = 1'b0;
        #1;
        check("stall in_ready", 32'(b_rr.in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall out_data c%0d", i), b_rr.out_data,        32'hA0);
            check($sformatf("stall out_ch c%0d", i),   32'(b_rr.out_ch),    32'd0);
            check($sformatf("stall in_ready c%0d", i), 32'(b_rr.in_ready),  32'd0);
        end
        check("stall xfer_cnt", 32'(b_rr.xfer_cnt), 32'd4);

        b_rr.out_ready = 1'b1;
        #1;
        check("post-stall in_ready", 32'(b_rr.in_ready), 32'b0010);
        step();
        check("post-stall out_ch",   32'(b_rr.out_ch),   32'd1);
        check("post-stall xfer_cnt", 32'(b_rr.xfer_cnt), 32'd5);

        // Pointer at 2, only 0 and 3 valid: search wraps forward to 3
        b_rr.in_valid = 4'b1001;
        b_rr.in_data[2*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        #1;
        check("rr skip in_ready", 32'(b_rr.in_ready), 32'b1000);
        step();
        check("rr skip out_ch",   32'(b_rr.out_ch), 32'd3);
        check("rr skip out_data", b_rr.out_data,     32'hA3);

        // Drain with no grant: valid drops, data/ch hold
        b_rr.in_valid = 4'b0000;
        #1;
        check("drain in_ready", 32'(b_rr.in_ready), 32'd0);
        step();
        check("drain out_valid", 32'(b_rr.out_valid), 32'd0);
        check("drain out_data",  b_rr.out_data,        32'hA3);
        check("drain out_ch",    32'(b_rr.out_ch),    32'd3);
        check("drain xfer_cnt",  32'(b_rr.xfer_cnt),  32'd7);

        // Fixed priority
        b_fp.in_valid = 4'b1010;
        #1;
        check("fp in_ready", 32'(b_fp.in_ready), 32'b0010);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("fp out_ch c%0d", i),   32'(b_fp.out_ch),   32'd1);
            check($sformatf("fp out_data c%0d", i), b_fp.out_data,       32'hB1);
            check($sformatf("fp in_ready c%0d", i), 32'(b_fp.in_ready), 32'b0010);
        end
        check("fp xfer_cnt", 32'(b_fp.xfer_cnt), 32'd2);
        b_fp.in_valid = 4'b1100;
        #1;
        check("fp lowest in_ready", 32'(b_fp.in_ready), 32'b0100);
        step();
        check("fp lowest out_ch",   32'(b_fp.out_ch),   32'd2);
        check("fp lowest out_data", b_fp.out_data,       32'hB2);

        // External select
        b_sel.sel      = 2'd2;
        b_sel.in_valid = 4'b0100;
        #1;
        check("sel2 in_ready", 32'(b_sel.in_ready), 32'b0100);
        step();
        check("sel2 out_data",  b_sel.out_data,        32'hDEADBEEF);
        check("sel2 out_ch",    32'(b_sel.out_ch),    32'd2);
        check("sel2 out_valid", 32'(b_sel.out_valid), 32'd1);
        b_sel.sel = 2'd3;
        #1;
        check("sel3 in_ready", 32'(b_sel.in_ready), 32'd0);
        step();
        check("sel3 out_valid", 32'(b_sel.out_valid), 32'd0);
        check("sel3 out_data",  b_sel.out_data,        32'hDEADBEEF);
        b_sel.sel      = 2'd0;
        b_sel.in_valid = 4'b0101;
        #1;
        check("sel0 in_ready", 32'(b_sel.in_ready), 32'b0001);
        step();
        check("sel0 out_data", b_sel.out_data,     32'hC0);
        check("sel0 out_ch",   32'(b_sel.out_ch), 32'd0);

        // Counter wrap: slot empty, count 7; first edge loads, then +1 per edge
        b_rr.in_valid = 4'hF;
        repeat (65529) @(posedge clk);
        #1;
        check("wrap pre xfer_cnt", 32'(b_rr.xfer_cnt), 32'hFFFF);
        step();
        check("wrap xfer_cnt",  32'(b_rr.xfer_cnt),  32'h0000);
        check("wrap out_valid", 32'(b_rr.out_valid), 32'd1);

        // Async reset mid-cycle with a word held
        #3;
        rst = 1'b1;
        #1;
        check("arst out_valid", 32'(b_rr.out_valid), 32'd0);
        check("arst out_data",  b_rr.out_data,        32'd0);
        check("arst out_ch",    32'(b_rr.out_ch),    32'd0);
        check("arst xfer_cnt",  32'(b_rr.xfer_cnt),  32'd0);
        check("arst in_ready",  32'(b_rr.in_ready),  32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("arst restart in_ready", 32'(b_rr.in_ready), 32'b0001);
        step();
        check("arst restart out_ch",   32'(b_rr.out_ch), 32'd0);
        check("arst restart out_data", b_rr.out_data,     32'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
